fg_dds_wavegen: RTL and testbench

//  Next-generation waveform source for the function generator. Replaces the fixed timer/counter

---
 rtl/fg_dds_wavegen.sv | 228 ++++++++++++++++++++++
 tb/tb_fg_dds_wavegen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_dds_wavegen.sv
// fg_dds_wavegen: prescaled DDS waveform source (DC, square/PWM, saw, triangle)
// with double-buffered configuration, glitch-free updates at period boundaries,
// burst mode, and an offset/saturation/radix output stage.
module fg_dds_wavegen #(
  parameter int BITWIDTH = 8,
  parameter int PHASE_W  = 16,
  parameter int PSC_W    = 9,
  parameter int BURST_W  = 8
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [1:0]          cfg_mode_i,
  input  logic [PSC_W-1:0]    cfg_psc_i,
  input  logic [PHASE_W-1:0]  cfg_fcw_i,
  input  logic [PHASE_W-1:0]  cfg_duty_i,
  input  logic [BITWIDTH-1:0] cfg_amp_i,
  input  logic [BITWIDTH-1:0] cfg_offset_i,
  input  logic                cfg_radix_i,
  input  logic [BURST_W-1:0]  cfg_burst_i,
  output logic [BITWIDTH-1:0] out_o,
  output logic                out_valid_o,
  output logic                wrap_o,
  output logic                busy_o
);

  localparam int B = BITWIDTH;
  localparam int P = PHASE_W;

  localparam logic [1:0] MODE_DC  = 2'd0;
  localparam logic [1:0] MODE_SQR = 2'd1;
  localparam logic [1:0] MODE_SAW = 2'd2;

  // Mid-scale (2^(B-1)) and the signed output limits
  localparam logic signed [B:0]   HALF  = {2'b01, {(B-1){1'b0}}};
  localparam logic signed [B+1:0] MAX_Y = {3'b000, {(B-1){1'b1}}};
  localparam logic signed [B+1:0] MIN_Y = {3'b111, {(B-1){1'b0}}};

  typedef struct packed {
    logic [1:0]         mode;
    logic [PSC_W-1:0]   psc;
    logic [P-1:0]       fcw;
    logic [P-1:0]       duty;
    logic [B-1:0]       amp;
    logic [B-1:0]       offset;
    logic               radix;
    logic [BURST_W-1:0] burst;
  } cfg_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  cfg_t               cfg_in;
  cfg_t               shadow_q;
  cfg_t               active_q;
  cfg_t               cfg_nxt;
  logic               shadow_full;
  logic               active_vld;
  state_t             state;
  logic [P-1:0]       phase;
  logic [P-1:0]       phase_sum;
  logic [P-1:0]       samp_phase;
  logic               carry;
  logic [PSC_W-1:0]   psc_cnt;
  logic [BURST_W-1:0] bcnt;
  logic               run;
  logic               accept;
  logic               tick;
  logic               wrap;
  logic               xfer;
  logic               burst_done;
  logic               run_nxt;
  logic [B-1:0]       out_p0;
  logic               vld_p0;
  logic               wrap_p0;

  // Clamp the B+2 bit sum to the signed B-bit range, then apply output radix
  function automatic logic [B-1:0] sat_radix(input logic signed [B+1:0] y, input logic radix);
    logic [B-1:0] r;
    if (y > MAX_Y)      r = MAX_Y[B-1:0];
    else if (y < MIN_Y) r = MIN_Y[B-1:0];
    else                r = y[B-1:0];
    if (radix) r[B-1] = ~r[B-1];
    return r;
  endfunction

  // Raw waveform value for one phase, followed by offset and saturation
  function automatic logic [B-1:0] wave_sample(input cfg_t c, input logic [P-1:0] ph);
    logic [B-1:0]            u;
    logic [B-1:0]            t;
    logic signed [B:0]       s;
    logic signed [B:0]       ts;
    logic signed [B:0]       amp_s;
    logic signed [B:0]       w;
    logic signed [2*B+1:0]   prod;
    logic signed [B+1:0]     y;
    u     = ph[P-1 -: B];
    amp_s = $signed({1'b0, c.amp});
    s     = $signed({1'b0, u}) - HALF;
    t     = u[B-1] ? ~u : u;
    ts    = $signed({1'b0, t[B-2:0], 1'b0}) - HALF;
    prod  = '0;
    case (c.mode)
      MODE_DC:  w = amp_s;
      MODE_SQR: w = (ph < c.duty) ? amp_s : -amp_s;
      MODE_SAW: begin
        prod = {{(B+1){s[B]}}, s} * {{(B+1){amp_s[B]}}, amp_s};
        w    = prod[B-1 +: B+1];
      end
      default: begin
        prod = {{(B+1){ts[B]}}, ts} * {{(B+1){amp_s[B]}}, amp_s};
        w    = prod[B-1 +: B+1];
      end
    endcase
    y = {w[B], w} + $signed({{2{c.offset[B-1]}}, c.offset});
    return sat_radix(y, c.radix);
  endfunction

  // Datapath-side control decode
  always_comb begin
    cfg_in.mode   = cfg_mode_i;
    cfg_in.psc    = cfg_psc_i;
    cfg_in.fcw    = cfg_fcw_i;
    cfg_in.duty   = cfg_duty_i;
    cfg_in.amp    = cfg_amp_i;
    cfg_in.offset = cfg_offset_i;
    cfg_in.radix  = cfg_radix_i;
    cfg_in.burst  = cfg_burst_i;
    run              = (state == S_RUN);
    accept           = cfg_valid_i & ~shadow_full;
    tick             = run & enable_i & (psc_cnt == active_q.psc);
    {carry, phase_sum} = {1'b0, phase} + {1'b0, active_q.fcw};
    wrap             = tick & carry;
    xfer             = shadow_full & (~run | wrap);
    burst_done       = wrap & (active_q.burst != '0) & ((bcnt + 1'b1) == active_q.burst);
    cfg_nxt          = xfer ? shadow_q : active_q;
    samp_phase       = xfer ? '0 : phase_sum;
    run_nxt          = enable_i & (xfer | (run & ~burst_done) | ((state == S_IDLE) & active_vld));
  end

  assign cfg_ready_o = ~shadow_full;
  assign busy_o      = run;

  // Shadow register: holds one pending word until it is promoted to active
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      shadow_full <= 1'b0;
      shadow_q    <= '0;
    end else if (accept) begin
      shadow_full <= 1'b1;
      shadow_q    <= cfg_in;
    end else if (xfer) begin
      shadow_full <= 1'b0;
    end
  end

  // Active configuration: only changes on a shadow transfer
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      active_vld <= 1'b0;
      active_q   <= '0;
    end else if (xfer) begin
      active_vld <= 1'b1;
      active_q   <= shadow_q;
    end
  end

  // Run-state FSM with prescaler, phase accumulator and burst counter
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      phase   <= '0;
      psc_cnt <= '0;
      bcnt    <= '0;
    end else if (!enable_i) begin
      state   <= S_IDLE;
      phase   <= '0;
      psc_cnt <= '0;
      bcnt    <= '0;
    end else if (xfer) begin
      state   <= S_RUN;
      phase   <= '0;
      psc_cnt <= '0;
      bcnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (active_vld) state <= S_RUN;
        S_RUN: begin
          if (tick) begin
            psc_cnt <= '0;
            if (burst_done) begin
              state <= S_STOP;
              phase <= '0;
              bcnt  <= bcnt + 1'b1;
            end else begin
              phase <= phase_sum;
              if (wrap && active_q.burst != '0) bcnt <= bcnt + 1'b1;
            end
          end else begin
            psc_cnt <= psc_cnt + 1'b1;
          end
        end
        S_STOP:  phase <= '0;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output stage (p0): sample of the post-tick phase; mid-scale when leaving RUN
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      out_p0  <= '0;
      vld_p0  <= 1'b0;
      wrap_p0 <= 1'b0;
    end else begin
      vld_p0  <= tick;
      wrap_p0 <= wrap;
      if (tick)          out_p0 <= wave_sample(cfg_nxt, samp_phase);
      else if (!run_nxt) out_p0 <= cfg_nxt.radix ? MIN_Y[B-1:0] : '0;
    end
  end

  assign out_o       = out_p0;
  assign out_valid_o = vld_p0;
  assign wrap_o      = wrap_p0;

endmodule

// File: tb/tb_fg_dds_wavegen.sv
// Directed bench for fg_dds_wavegen (B=8, P=16): vector table of first samples
// plus hand-written multi-cycle sequences for prescaler, burst, update and enable.
module tb_fg_dds_wavegen;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [1:0]  cfg_mode_i;
  logic [8:0]  cfg_psc_i;
  logic [15:0] cfg_fcw_i;
  logic [15:0] cfg_duty_i;
  logic [7:0]  cfg_amp_i;
  logic [7:0]  cfg_offset_i;
  logic        cfg_radix_i;
  logic [7:0]  cfg_burst_i;
  logic [7:0]  out_o;
  logic        out_valid_o;
  logic        wrap_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  fg_dds_wavegen dut (
    .clk_i(clk_i), .rst_n(rst_n), .enable_i(enable_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_mode_i(cfg_mode_i), .cfg_psc_i(cfg_psc_i), .cfg_fcw_i(cfg_fcw_i),
    .cfg_duty_i(cfg_duty_i), .cfg_amp_i(cfg_amp_i), .cfg_offset_i(cfg_offset_i),
    .cfg_radix_i(cfg_radix_i), .cfg_burst_i(cfg_burst_i),
    .out_o(out_o), .out_valid_o(out_valid_o), .wrap_o(wrap_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  mode;
    logic [8:0]  psc;
    logic [15:0] fcw;
    logic [15:0] duty;
    logic [7:0]  amp;
    logic [7:0]  offset;
    logic        radix;
    logic [7:0]  burst;
  } cfg_t;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] fcw;
    logic [15:0] duty;
    logic [7:0]  amp;
    logic [7:0]  offset;
    logic        radix;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs [15];

  function automatic cfg_t mk(input logic [1:0] mode, input logic [8:0] psc,
                              input logic [15:0] fcw, input logic [15:0] duty,
                              input logic [7:0] amp, input logic [7:0] offset,
                              input logic radix, input logic [7:0] burst);
    cfg_t c;
    c.mode = mode; c.psc = psc; c.fcw = fcw; c.duty = duty;
    c.amp = amp; c.offset = offset; c.radix = radix; c.burst = burst;
    return c;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_cfg(input cfg_t c);
    cfg_mode_i = c.mode; cfg_psc_i = c.psc; cfg_fcw_i = c.fcw; cfg_duty_i = c.duty;
    cfg_amp_i = c.amp; cfg_offset_i = c.offset; cfg_radix_i = c.radix; cfg_burst_i = c.burst;
  endtask

  // Present a word and return just after the edge that accepted it
  task automatic send_cfg(input cfg_t c);
    int n;
    n = 0;
    drive_cfg(c);
    cfg_valid_i = 1'b1;
    while (!cfg_ready_o && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
    step();
    cfg_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_valid_i = 1'b0;
    enable_i = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Step until wrap_o is seen (bounded); found reports whether it was
  task automatic wait_wrap(output logic found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (wrap_o) found = 1'b1;
    end
  endtask

  initial begin
    int   nv, nw, first_t, second_t;
    logic found;
    logic rdy_high;
    logic [7:0] seen [4];

    // {mode, fcw, duty, amp, offset, radix, expected first sample}
    vecs[0]  = '{2'd2, 16'h1000, 16'h0000, 8'd127, 8'h00, 1'b0, 8'h90};
    vecs[1]  = '{2'd2, 16'hF000, 16'h0000, 8'd127, 8'h00, 1'b0, 8'h6F};
    vecs[2]  = '{2'd2, 16'h8000, 16'h0000, 8'd200, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{2'd1, 16'h1000, 16'h8000, 8'd100, 8'd50,  1'b0, 8'h7F};
    vecs[4]  = '{2'd1, 16'h9000, 16'h8000, 8'd100, 8'd50,  1'b0, 8'hCE};
    vecs[5]  = '{2'd1, 16'h1000, 16'h8000, 8'd100, 8'd50,  1'b1, 8'hFF};
    vecs[6]  = '{2'd1, 16'h9000, 16'h8000, 8'd100, 8'd50,  1'b1, 8'h4E};
    vecs[7]  = '{2'd0, 16'h1000, 16'h0000, 8'd100, 8'hEC, 1'b0, 8'h50};
    vecs[8]  = '{2'd0, 16'h1000, 16'h0000, 8'd255, 8'd127, 1'b0, 8'h7F};
    vecs[9]  = '{2'd1, 16'h9000, 16'h8000, 8'd255, 8'h80, 1'b0, 8'h80};
    vecs[10] = '{2'd3, 16'h4000, 16'h0000, 8'd127, 8'h00, 1'b0, 8'h00};
    vecs[11] = '{2'd3, 16'h2000, 16'h0000, 8'd127, 8'h00, 1'b0, 8'hC0};
    vecs[12] = '{2'd3, 16'hC000, 16'h0000, 8'd127, 8'h00, 1'b0, 8'hFE};
    vecs[13] = '{2'd3, 16'h8000, 16'h0000, 8'd127, 8'h00, 1'b0, 8'h7D};
    vecs[14] = '{2'd2, 16'h1000, 16'h0000, 8'd127, 8'd10,  1'b1, 8'h1A};

    rst_n = 1'b0; enable_i = 1'b0; cfg_valid_i = 1'b0;
    drive_cfg(mk(2'd0, 9'd0, 16'h0, 16'h0, 8'd0, 8'd0, 1'b0, 8'd0));
    step();
    step();
    check("rst_ready", {31'd0, cfg_ready_o}, 32'd1);
    check("rst_out", {24'd0, out_o}, 32'd0);
    check("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_wrap", {31'd0, wrap_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);

    // First sample after start, one vector per reset
    for (int i = 0; i < 15; i++) begin
      do_reset();
      send_cfg(mk(vecs[i].mode, 9'd0, vecs[i].fcw, vecs[i].duty, vecs[i].amp,
                  vecs[i].offset, vecs[i].radix, 8'd0));
      step();
      step();
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid_o}, 32'd1);
      check($sformatf("vec%0d_out", i), {24'd0, out_o}, {24'd0, vecs[i].exp_out});
    end

    // Continuous saw: strobe every clock, wrap every 16 samples
    do_reset();
    send_cfg(mk(2'd2, 9'd0, 16'h1000, 16'h0, 8'd127, 8'd0, 1'b0, 8'd0));
    step();
    check("saw_busy", {31'd0, busy_o}, 32'd1);
    nv = 0; nw = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (out_valid_o) nv++;
      if (wrap_o) nw++;
      if (k == 8)  check("saw_mid", {24'd0, out_o}, 32'h00);
      if (k == 15) check("saw_top", {24'd0, out_o}, 32'h6F);
      if (k == 16) begin
        check("saw_wrap_out", {24'd0, out_o}, 32'h81);
        check("saw_wrap_flag", {31'd0, wrap_o}, 32'd1);
      end
    end
    check("saw_strobes", nv, 32);
    check("saw_wraps", nw, 2);

    // Prescaled square: one strobe every 4 clocks, alternating saturated/low
    do_reset();
    send_cfg(mk(2'd1, 9'd3, 16'h8000, 16'h8000, 8'd100, 8'd50, 1'b0, 8'd0));
    nv = 0; first_t = 0; second_t = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (out_valid_o) begin
        if (nv < 4) seen[nv] = out_o;
        if (nv == 0) first_t = k;
        if (nv == 1) second_t = k;
        nv++;
      end
    end
    check("sqr_strobes", nv, 4);
    check("sqr_spacing", second_t - first_t, 4);
    check("sqr_s0", {24'd0, seen[0]}, 32'hCE);
    check("sqr_s1", {24'd0, seen[1]}, 32'h7F);
    check("sqr_s2", {24'd0, seen[2]}, 32'hCE);

    // Burst of 2 periods then STOP; new word restarts
    do_reset();
    send_cfg(mk(2'd2, 9'd0, 16'h4000, 16'h0, 8'd127, 8'd0, 1'b0, 8'd2));
    nv = 0; nw = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (out_valid_o) nv++;
      if (wrap_o) nw++;
    end
    check("burst_strobes", nv, 8);
    check("burst_wraps", nw, 2);
    check("burst_busy", {31'd0, busy_o}, 32'd0);
    check("burst_out", {24'd0, out_o}, 32'd0);
    send_cfg(mk(2'd2, 9'd0, 16'h4000, 16'h0, 8'd127, 8'd0, 1'b0, 8'd0));
    step();
    check("burst_restart", {31'd0, busy_o}, 32'd1);

    // Live update: applies at the wrap, second word stalls while shadow full
    do_reset();
    send_cfg(mk(2'd2, 9'd0, 16'h1000, 16'h0, 8'd127, 8'd0, 1'b0, 8'd0));
    for (int k = 0; k < 5; k++) step();
    drive_cfg(mk(2'd2, 9'd0, 16'h1000, 16'h0, 8'd64, 8'd0, 1'b0, 8'd0));
    cfg_valid_i = 1'b1;
    step();
    drive_cfg(mk(2'd2, 9'd0, 16'h1000, 16'h0, 8'd32, 8'd0, 1'b0, 8'd0));
    check("upd_stall", {31'd0, cfg_ready_o}, 32'd0);
    rdy_high = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (wrap_o) found = 1'b1;
      else if (cfg_ready_o) rdy_high = 1'b1;
    end
    check("upd_wrap_seen", {31'd0, found}, 32'd1);
    check("upd_ready_low", {31'd0, rdy_high}, 32'd0);
    check("upd_first_amp64", {24'd0, out_o}, 32'hC0);
    check("upd_ready_back", {31'd0, cfg_ready_o}, 32'd1);
    step();
    cfg_valid_i = 1'b0;
    check("upd_amp64_k1", {24'd0, out_o}, 32'hC8);
    wait_wrap(found);
    check("upd_wrap2_seen", {31'd0, found}, 32'd1);
    check("upd_amp32", {24'd0, out_o}, 32'hE0);

    // Enable drop, restart at phase 0, then reset mid-run
    do_reset();
    send_cfg(mk(2'd2, 9'd0, 16'h1000, 16'h0, 8'd127, 8'd0, 1'b1, 8'd0));
    for (int k = 0; k < 5; k++) step();
    enable_i = 1'b0;
    step();
    check("dis_busy", {31'd0, busy_o}, 32'd0);
    check("dis_valid", {31'd0, out_valid_o}, 32'd0);
    check("dis_out_mid", {24'd0, out_o}, 32'h80);
    enable_i = 1'b1;
    step();
    check("reen_busy", {31'd0, busy_o}, 32'd1);
    step();
    check("reen_valid", {31'd0, out_valid_o}, 32'd1);
    check("reen_phase0", {24'd0, out_o}, 32'h10);
    rst_n = 1'b0;
    step();
    check("mrst_busy", {31'd0, busy_o}, 32'd0);
    check("mrst_out", {24'd0, out_o}, 32'd0);
    check("mrst_valid", {31'd0, out_valid_o}, 32'd0);
    check("mrst_ready", {31'd0, cfg_ready_o}, 32'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("mrst_no_active", {31'd0, busy_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
